// File: rtl/pc_sequencer.sv
// PC redirect/stall sequencer: arbitrates EX branches and ID jumps, buffers
// redirects that arrive while fetch cannot advance, and tracks memory waits.
module pc_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_exBranchTaken,
   input  logic [31:0] i_exBranchTarget,
   input  logic        i_idJumpValid,
   input  logic [31:0] i_idJumpTarget,
   input  logic        i_hazardStall,
   input  logic        i_imemReady,
   input  logic        i_haltRequest,
   input  logic        i_resumeRequest,
   output logic        o_pcStall,
   output logic        o_pcJumpEnabled,
   output logic [31:0] o_pcJumpValue,
   output logic        o_flushIF,
   output logic        o_flushID,
   output logic [1:0]  o_state,
   output logic        o_pendingValid,
   output logic        o_memTimeout,
   output logic [15:0] o_stallCycles
);

   localparam int unsigned WAIT_W  = 8;
   localparam int unsigned STALL_W = 16;
   localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 r_pend_valid;
   logic                 r_pend_from_ex;
   logic [31:0]          r_pend_target;
   logic [WAIT_W-1:0]    r_wait_cnt;
   logic                 r_mem_timeout;
   logic [STALL_W-1:0]   r_stall_cnt;

   logic                 w_advance;
   logic                 w_live_valid;
   logic [31:0]          w_live_target;
   logic                 w_use_pending;
   logic                 w_live_accept;
   logic                 w_eff_valid;
   logic [31:0]          w_eff_target;
   logic                 w_eff_from_ex;
   logic [WAIT_W-1:0]    w_wait_inc;
   logic                 w_pend_valid_next;
   logic                 w_pend_from_ex_next;
   logic [31:0]          w_pend_target_next;

   // Redirect arbitration: a live EX branch beats both a live ID jump and a
   // buffered ID jump, since the ID jump sits on a path EX just squashed.
   assign w_advance     = (r_state == ST_RUN) & i_imemReady & ~i_hazardStall;
   assign w_live_valid  = i_exBranchTaken | i_idJumpValid;
   assign w_live_target = i_exBranchTaken ? i_exBranchTarget : i_idJumpTarget;
   assign w_use_pending = r_pend_valid & ~(i_exBranchTaken & ~r_pend_from_ex);
   assign w_live_accept = w_live_valid & ~(r_pend_valid & r_pend_from_ex & ~i_exBranchTaken);
   assign w_eff_valid   = w_use_pending | w_live_valid;
   assign w_eff_target  = w_use_pending ? r_pend_target  : w_live_target;
   assign w_eff_from_ex = w_use_pending ? r_pend_from_ex : i_exBranchTaken;
   assign w_wait_inc    = (r_wait_cnt == {WAIT_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);

   assign o_pcStall       = ~w_advance;
   assign o_pcJumpEnabled = w_eff_valid;
   assign o_pcJumpValue   = w_eff_valid ? w_eff_target : 32'h0;
   assign o_flushIF       = w_advance & w_eff_valid;
   assign o_flushID       = w_advance & w_eff_valid & w_eff_from_ex;
   assign o_state         = r_state;
   assign o_pendingValid  = r_pend_valid;
   assign o_memTimeout    = r_mem_timeout;
   assign o_stallCycles   = r_stall_cnt;

   // Next state of the fetch FSM
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN: begin
            if (i_haltRequest)     w_state_next = ST_HALT;
            else if (!i_imemReady) w_state_next = ST_WAIT_MEM;
         end
         ST_WAIT_MEM: begin
            if (i_haltRequest)     w_state_next = ST_HALT;
            else if (i_imemReady)  w_state_next = ST_RUN;
         end
         ST_HALT: begin
            if (i_resumeRequest && !i_haltRequest) w_state_next = ST_RUN;
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   // Pending buffer: consumed when fetch advances, refilled by any redirect that
   // could not be applied this cycle.
   always_comb begin
      w_pend_valid_next   = r_pend_valid;
      w_pend_from_ex_next = r_pend_from_ex;
      w_pend_target_next  = r_pend_target;
      if (w_advance) begin
         if (w_use_pending && w_live_accept) begin
            w_pend_valid_next   = 1'b1;
            w_pend_from_ex_next = i_exBranchTaken;
            w_pend_target_next  = w_live_target;
         end else begin
            w_pend_valid_next   = 1'b0;
         end
      end else if (w_live_accept) begin
         w_pend_valid_next   = 1'b1;
         w_pend_from_ex_next = i_exBranchTaken;
         w_pend_target_next  = w_live_target;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_pend_valid   <= 1'b0;
         r_pend_from_ex <= 1'b0;
         r_pend_target  <= 32'h0;
      end else begin
         r_pend_valid   <= w_pend_valid_next;
         r_pend_from_ex <= w_pend_from_ex_next;
         r_pend_target  <= w_pend_target_next;
      end
   end

   // Memory-wait counter and sticky timeout
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else if (r_state == ST_WAIT_MEM) begin
         if (w_wait_inc >= TIMEOUT_LIM) r_mem_timeout <= 1'b1;
         r_wait_cnt <= (w_state_next == ST_WAIT_MEM) ? w_wait_inc : '0;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_stall_cnt <= '0;
      end else if (o_pcStall && (r_stall_cnt != {STALL_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

   localparam int unsigned T = 255;

   logic        clk;
   logic        rst;
   logic        ex, id, haz, rdy, halt, resume;
   logic [31:0] ex_t, id_t;
   logic        pc_stall, jen, fif, fid, pv, mto;
   logic [31:0] jval;
   logic [1:0]  st;
   logic [15:0] sc;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: plain integers and a one-entry redirect record
   int          m_state;
   bit          m_pv, m_pex, m_to;
   logic [31:0] m_pt;
   int          m_wait, m_sc;
   // Model combinational view
   bit          e_adv, e_usep, e_jen, e_fif, e_fid, l_v, l_ex;
   logic [31:0] e_jval, l_t;

   pc_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .i_clock(clk), .i_reset(rst),
      .i_exBranchTaken(ex), .i_exBranchTarget(ex_t),
      .i_idJumpValid(id), .i_idJumpTarget(id_t),
      .i_hazardStall(haz), .i_imemReady(rdy),
      .i_haltRequest(halt), .i_resumeRequest(resume),
      .o_pcStall(pc_stall), .o_pcJumpEnabled(jen), .o_pcJumpValue(jval),
      .o_flushIF(fif), .o_flushID(fid), .o_state(st),
      .o_pendingValid(pv), .o_memTimeout(mto), .o_stallCycles(sc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_pv = 0; m_pex = 0; m_pt = 0;
      m_wait = 0;  m_to = 0; m_sc = 0;
   endtask

   task automatic model_eval();
      e_adv  = (m_state == 0) && rdy && !haz;
      l_v    = ex || id;
      l_ex   = ex;
      l_t    = ex ? ex_t : id_t;
      e_usep = m_pv && !(ex && !m_pex);
      e_jen  = e_usep || l_v;
      e_jval = !e_jen ? 32'h0 : (e_usep ? m_pt : l_t);
      e_fif  = e_adv && e_jen;
      e_fid  = e_fif && (e_usep ? m_pex : l_ex);
   endtask

   task automatic model_update();
      int  ns;
      int  inc;
      bit  live_ok;
      live_ok = l_v && !(m_pv && m_pex && !l_ex);
      ns = m_state;
      if (m_state == 0)      ns = halt ? 2 : (!rdy ? 1 : 0);
      else if (m_state == 1) ns = halt ? 2 : (rdy ? 0 : 1);
      else if (resume && !halt) ns = 0;
      if (m_state == 1) begin
         inc = (m_wait < 255) ? m_wait + 1 : 255;
         if (inc >= int'(T)) m_to = 1;
         m_wait = (ns == 1) ? inc : 0;
      end else begin
         m_wait = 0;
      end
      if (!e_adv && m_sc < 65535) m_sc++;
      if (e_adv && !(e_usep && live_ok)) m_pv = 0;
      else if (live_ok) begin m_pv = 1; m_pex = l_ex; m_pt = l_t; end
      m_state = ns;
   endtask

   // Mid-cycle compare of every output against the model
   task automatic settle();
      #3;
      if (!rst) model_reset();
      model_eval();
      check("pcStall", 32'(pc_stall), 32'(!e_adv));
      check("pcJumpEnabled", 32'(jen), 32'(e_jen));
      check("pcJumpValue", jval, e_jval);
      check("flushIF", 32'(fif), 32'(e_fif));
      check("flushID", 32'(fid), 32'(e_fid));
      check("state", 32'(st), 32'(m_state));
      check("pendingValid", 32'(pv), 32'(m_pv));
      check("memTimeout", 32'(mto), 32'(m_to));
      check("stallCycles", 32'(sc), 32'(m_sc));
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (rst) model_update();
      #1;
   endtask

   task automatic idle_inputs();
      ex = 0; id = 0; haz = 0; rdy = 1; halt = 0; resume = 0;
      ex_t = 32'h0; id_t = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 0;
      settle();
      edge_step();
      rst = 1;
   endtask

   initial begin
      idle_inputs();
      rst = 0;
      #1;
      settle();
      check("reset_state", 32'(st), 32'd0);
      check("reset_pending", 32'(pv), 32'd0);
      check("reset_stallcnt", 32'(sc), 32'd0);
      check("reset_timeout", 32'(mto), 32'd0);
      edge_step();
      rst = 1;

      // Taken EX branch applied in the same cycle
      ex = 1; ex_t = 32'h0000_3040;
      settle();
      check("ex_jen", 32'(jen), 32'd1);
      check("ex_jval", jval, 32'h0000_3040);
      check("ex_flushIF", 32'(fif), 32'd1);
      check("ex_flushID", 32'(fid), 32'd1);
      check("ex_stall", 32'(pc_stall), 32'd0);
      edge_step();

      // EX beats ID when both fire together
      ex = 1; ex_t = 32'h3100; id = 1; id_t = 32'h3200;
      settle();
      check("prio_jval", jval, 32'h0000_3100);
      check("prio_flushID", 32'(fid), 32'd1);
      edge_step();

      // ID jump buffered across a two-cycle hazard
      do_reset();
      ex = 0; id = 1; id_t = 32'h3080; haz = 1;
      settle();
      check("hz_stall0", 32'(pc_stall), 32'd1);
      edge_step();
      settle();
      check("hz_pending", 32'(pv), 32'd1);
      check("hz_stall1", 32'(pc_stall), 32'd1);
      edge_step();
      id = 0; haz = 0;
      settle();
      check("hz_jval", jval, 32'h0000_3080);
      check("hz_flushIF", 32'(fif), 32'd1);
      check("hz_flushID", 32'(fid), 32'd0);
      edge_step();
      settle();
      check("hz_cleared", 32'(pv), 32'd0);
      edge_step();

      // Long memory wait crossing the timeout
      do_reset();
      rdy = 0;
      for (int i = 0; i < 300; i++) begin
         settle();
         if (i == 255) check("to_not_yet", 32'(mto), 32'd0);
         if (i == 256) check("to_set", 32'(mto), 32'd1);
         edge_step();
      end
      rdy = 1;
      settle();
      check("wait_state", 32'(st), 32'd1);
      check("wait_stallcnt", 32'(sc), 32'd300);
      edge_step();
      settle();
      check("wait_back_run", 32'(st), 32'd0);
      check("wait_to_sticky", 32'(mto), 32'd1);
      edge_step();

      // Halt / resume handshake
      do_reset();
      halt = 1;
      settle();
      edge_step();
      halt = 1; resume = 1;
      settle();
      check("halt_state", 32'(st), 32'd2);
      check("halt_stall", 32'(pc_stall), 32'd1);
      edge_step();
      halt = 0; resume = 1;
      settle();
      check("halt_hold", 32'(st), 32'd2);
      edge_step();
      resume = 0;
      settle();
      check("halt_resumed", 32'(st), 32'd0);
      edge_step();

      // Reset in the middle of a stall discards a buffered EX redirect
      do_reset();
      haz = 1; ex = 1; ex_t = 32'h5000;
      settle();
      edge_step();
      ex = 0;
      settle();
      check("rst_pend_before", 32'(pv), 32'd1);
      edge_step();
      rst = 0;
      settle();
      check("rst_pend", 32'(pv), 32'd0);
      check("rst_stallcnt", 32'(sc), 32'd0);
      check("rst_state", 32'(st), 32'd0);
      edge_step();
      rst = 1; haz = 0;
      settle();
      check("rst_no_jump", 32'(jen), 32'd0);
      edge_step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 299) != 0);
         ex     = ($urandom_range(0, 5) == 0);
         id     = ($urandom_range(0, 4) == 0);
         ex_t   = $urandom;
         id_t   = $urandom;
         haz    = ($urandom_range(0, 3) == 0);
         rdy    = ($urandom_range(0, 4) != 0);
         halt   = ($urandom_range(0, 29) == 0);
         resume = ($urandom_range(0, 3) == 0);
         settle();
         edge_step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: memory-wait cycles, 8-bit range, before memTimeout asserts.
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 exBranchTaken  input  1  EX stage resolves a taken branch this cycle.
REQ-005 exBranchTarget  input  32  target of the EX branch.
REQ-006 idJumpValid  input  1  ID stage decodes a jump this cycle.
REQ-007 idJumpTarget  input  32  target of the ID jump.
REQ-008 hazardStall  input  1  load-use hazard; PC must hold.
REQ-009 imemReady  input  1  instruction fetch at current PC completes this cycle.
REQ-010 haltRequest  input  1  request to freeze fetch.
REQ-011 resumeRequest  input  1  request to leave HALT.
REQ-012 pcStall  output  1  drives the program counter's stall input.
REQ-013 pcJumpEnabled  output  1  drives the program counter's jump enable.
REQ-014 pcJumpValue  output  32  drives the program counter's jump value.
REQ-015 flushIF  output  1  squash the IF/ID register this cycle.
REQ-016 flushID  output  1  squash the ID/EX register this cycle.
REQ-017 state  output  2  RUN=0, WAIT_MEM=1, HALT=2.
REQ-018 pendingValid  output  1  a redirect is buffered.
REQ-019 memTimeout  output  1  sticky memory-wait timeout flag.
REQ-020 stallCycles  output  16  saturating count of cycles with pcStall=1.

Function
REQ-021 advance = (state==RUN) & imemReady & !hazardStall; pcStall = !advance, combinational.
REQ-022 Live redirect: EX branch has priority over ID jump; both high the same cycle -> EX target selected.
REQ-023 Effective redirect: pending buffer if pendingValid, else live redirect; exception: a live EX branch overrides a pending ID-sourced redirect.
REQ-024 pcJumpEnabled = 1 whenever an effective redirect exists; pcJumpValue = its target, else 0.
REQ-025 Redirect applied in a cycle with advance=1; flushIF=1 in that cycle; flushID=1 additionally iff the applied redirect came from EX.
REQ-026 Redirect present with advance=0: captured at next edge into pending (target + fromEx bit); EX capture overwrites pending ID entry; ID capture ignored while pending holds an EX entry.
REQ-027 Pending cleared on the edge ending an advance cycle, unless a new redirect is captured in that same cycle (REQ-026 rules apply).
REQ-028 FSM RUN: haltRequest -> HALT; else imemReady=0 -> WAIT_MEM; else stay.
REQ-029 FSM WAIT_MEM: haltRequest -> HALT; else imemReady=1 -> RUN; else stay; 8-bit wait counter increments per WAIT_MEM cycle, saturates at 255.
REQ-030 Wait counter reaching TIMEOUT_CYCLES sets memTimeout; memTimeout clears only on reset; counter zeroed on leaving WAIT_MEM.
REQ-031 FSM HALT: resumeRequest & !haltRequest -> RUN; otherwise stay; pending retained across HALT.
REQ-032 stallCycles increments on every edge where pcStall=1, saturating at 16'hFFFF.
REQ-033 flushIF/flushID never assert while pcStall=1.

Reset
REQ-034 reset=0 asynchronously forces state=RUN, pendingValid=0, pending target=0, wait counter=0, memTimeout=0, stallCycles=0.
REQ-035 During reset all combinational outputs derive from reset state; pending redirect in flight is discarded; first edge after release behaves as RUN.

Verification
REQ-036 RUN, imemReady=1, exBranchTaken=1 target 0x00003040 -> same cycle pcJumpEnabled=1, pcJumpValue=0x00003040, flushIF=1, flushID=1, pcStall=0.
REQ-037 exBranchTaken (0x3100) and idJumpValid (0x3200) same cycle, advance=1 -> pcJumpValue=0x00003100, flushID=1.
REQ-038 idJumpValid target 0x3080 with hazardStall=1 for 2 cycles -> pendingValid=1 from next cycle, pcStall=1; on first cycle hazardStall=0 pcJumpValue=0x3080, flushIF=1, flushID=0; pendingValid=0 after.
REQ-039 imemReady=0 for 300 cycles, TIMEOUT_CYCLES=255 -> state=WAIT_MEM, memTimeout=1 after 255 wait cycles, stallCycles=300; imemReady=1 -> state RUN next cycle, memTimeout stays 1.
REQ-040 haltRequest 1 cycle -> HALT, pcStall=1; resumeRequest with haltRequest=1 -> stays HALT; resumeRequest alone -> RUN.
REQ-041 Pending EX redirect, then reset=0 mid-stall -> pendingValid=0, stallCycles=0, state=RUN immediately; no jump after release.
